// File: rtl/grey_nkb_tracker_if.sv
// Bundle of the tracker's control inputs and its decode/classification results.
// Pure wiring: no latency is added by the interface itself.
// No backpressure: grey_in is free-running and the results are plain level/pulse outputs.
interface grey_nkb_tracker_if #(
  parameter int W     = 4,
  parameter int POS_W = 16
);
  logic             en;
  logic             clr;
  logic [W-1:0]     grey_in;
  logic [W-1:0]     bin_out;
  logic             valid;
  logic             step_up;
  logic             step_dn;
  logic             err;
  logic [POS_W-1:0] pos;
  logic [7:0]       err_cnt;

  // Driver side: supplies the Gray word and accumulator controls.
  modport master (
    output en, clr, grey_in,
    input  bin_out, valid, step_up, step_dn, err, pos, err_cnt
  );

  // Tracker side.
  modport slave (
    input  en, clr, grey_in,
    output bin_out, valid, step_up, step_dn, err, pos, err_cnt
  );
endinterface

// File: rtl/grey_nkb_tracker.sv
// Synchronizes an async Gray word, decodes it to binary, classifies each change as +1/-1/jump and accumulates.
// Latency: grey_in -> bin_out/pulses SYNC_STAGES+1 edges; pos/err_cnt one edge after the pulse.
// No backpressure: every sample is decoded; en only gates the accumulators.
module grey_nkb_tracker #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int POS_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  grey_nkb_tracker_if.slave trk
);

  localparam logic [W-1:0] DIFF_UP = W'(1);
  localparam logic [W-1:0] DIFF_DN = '1;

  // Synchronizer chain for the Gray word; index SYNC_STAGES-1 is the last stage.
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  // Parallel chain of 1s tracking which stages hold a post-reset sample, so the
  // first classified sample is a real grey_in value, not the flops' reset zeros.
  logic [SYNC_STAGES-1:0]        fill_q, fill_d;

  logic [W-1:0]     g_s;
  logic [W-1:0]     b_dec;
  logic [W-1:0]     diff;

  // bin_q doubles as the previous-sample register: both load the decode every cycle.
  logic [W-1:0]     bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  assign g_s = sync_q[SYNC_STAGES-1];

  // Shift the Gray word and the fill marker one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trk.grey_in};
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_dec = '0;
    for (int i = 0; i < W; i++) begin
      b_dec[i] = ^(g_s >> i);
    end
  end

  // Classify the change against the previous sample; pulses only once valid is established.
  always_comb begin
    diff      = b_dec - bin_q;
    bin_d     = b_dec;
    valid_d   = valid_q | fill_q[SYNC_STAGES-1];
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    err_d     = 1'b0;
    if (valid_q) begin
      if (diff == DIFF_UP) begin
        step_up_d = 1'b1;
      end else if (diff == DIFF_DN) begin
        step_dn_d = 1'b1;
      end else if (diff != '0) begin
        err_d = 1'b1;
      end
    end
  end

  // Accumulate last cycle's pulse; clr wins over a coincident event.
  always_comb begin
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    if (trk.clr) begin
      pos_d     = '0;
      err_cnt_d = '0;
    end else if (trk.en) begin
      if (step_up_q) begin
        pos_d = pos_q + POS_W'(1);
      end else if (step_dn_q) begin
        pos_d = pos_q - POS_W'(1);
      end
      if (err_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      fill_q    <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign trk.bin_out = bin_q;
  assign trk.valid   = valid_q;
  assign trk.step_up = step_up_q;
  assign trk.step_dn = step_dn_q;
  assign trk.err     = err_q;
  assign trk.pos     = pos_q;
  assign trk.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_grey_nkb_tracker.sv
// Directed bench for grey_nkb_tracker: reset, counting, wrap, jumps, saturation, en/clr, mid-run reset.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Pulse counts are accumulated by the tick task so single-cycle pulses are never missed.
module tb_grey_nkb_tracker;
  localparam int W     = 4;
  localparam int POS_W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  grey_nkb_tracker_if #(.W(W), .POS_W(POS_W)) trk_if ();

  grey_nkb_tracker #(.W(W), .SYNC_STAGES(2), .POS_W(POS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trk   (trk_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_up, n_dn, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic clear_counts();
    n_up  = 0;
    n_dn  = 0;
    n_err = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      n_up  += int'(trk_if.step_up);
      n_dn  += int'(trk_if.step_dn);
      n_err += int'(trk_if.err);
    end
  endtask

  // Apply a binary value as its Gray code and let it settle through to the accumulators.
  task automatic drive(input int b);
    trk_if.grey_in = to_gray(b);
    tick(4);
  endtask

  initial begin
    rst_n          = 1'b0;
    trk_if.en      = 1'b1;
    trk_if.clr     = 1'b0;
    trk_if.grey_in = 4'b0110;
    clear_counts();

    // Reset state
    tick(3);
    check("rst_valid",   32'(trk_if.valid),   0);
    check("rst_bin",     32'(trk_if.bin_out), 0);
    check("rst_pos",     32'(trk_if.pos),     0);
    check("rst_err_cnt", 32'(trk_if.err_cnt), 0);
    check("rst_pulses",  32'(n_up + n_dn + n_err), 0);

    // First sample: Gray 0110 -> binary 4, no pulse
    rst_n = 1'b1;
    clear_counts();
    tick(2);
    check("first_valid_early", 32'(trk_if.valid), 0);
    tick(1);
    check("first_valid",  32'(trk_if.valid),   1);
    check("first_bin",    32'(trk_if.bin_out), 4);
    check("first_pulses", 32'(n_up + n_dn + n_err), 0);
    tick(1);
    check("first_pos",    32'(trk_if.pos),     0);

    // 4 -> 0 is a jump; then clear the counters
    drive(0);
    check("to0_err",     32'(n_err),          1);
    check("to0_err_cnt", 32'(trk_if.err_cnt), 1);
    trk_if.clr = 1'b1;
    tick(1);
    trk_if.clr = 1'b0;
    check("clr_err_cnt", 32'(trk_if.err_cnt), 0);
    check("clr_pos",     32'(trk_if.pos),     0);

    // Up count 0..4
    clear_counts();
    for (int b = 1; b <= 4; b++) begin
      drive(b);
      check("up_bin", 32'(trk_if.bin_out), 32'(b));
    end
    check("up_n_up",   32'(n_up),           4);
    check("up_n_other", 32'(n_dn + n_err),  0);
    check("up_pos",    32'(trk_if.pos),     4);
    check("up_err_cnt", 32'(trk_if.err_cnt), 0);

    // Climb to 15, then wrap up to 0 and back down to 15
    for (int b = 5; b <= 15; b++) drive(b);
    check("climb_pos", 32'(trk_if.pos),     15);
    check("climb_bin", 32'(trk_if.bin_out), 15);
    clear_counts();
    drive(0);
    check("wrap_up_bin", 32'(trk_if.bin_out), 0);
    check("wrap_up_n",   32'(n_up),           1);
    check("wrap_up_pos", 32'(trk_if.pos),     16);
    drive(15);
    check("wrap_dn_bin", 32'(trk_if.bin_out), 15);
    check("wrap_dn_n",   32'(n_dn),           1);
    check("wrap_dn_pos", 32'(trk_if.pos),     15);
    check("wrap_no_err", 32'(n_err),          0);

    // Illegal jump 2 -> 6
    drive(0);
    drive(1);
    drive(2);
    clear_counts();
    drive(6);
    check("jump_n_err",   32'(n_err),          1);
    check("jump_n_step",  32'(n_up + n_dn),    0);
    check("jump_err_cnt", 32'(trk_if.err_cnt), 1);
    check("jump_pos",     32'(trk_if.pos),     18);
    check("jump_bin",     32'(trk_if.bin_out), 6);

    // 300 more alternating jumps: counter saturates
    for (int i = 1; i <= 300; i++) begin
      trk_if.grey_in = (i % 2 == 1) ? to_gray(2) : to_gray(6);
      tick(2);
    end
    tick(4);
    check("sat_n_err",   32'(n_err),          301);
    check("sat_err_cnt", 32'(trk_if.err_cnt), 255);
    check("sat_pos",     32'(trk_if.pos),     18);
    check("sat_bin",     32'(trk_if.bin_out), 6);

    // en = 0: pulses continue, accumulators hold, no catch-up on re-enable
    trk_if.en = 1'b0;
    clear_counts();
    drive(7);
    drive(8);
    drive(9);
    check("dis_n_up",    32'(n_up),           3);
    check("dis_pos",     32'(trk_if.pos),     18);
    check("dis_err_cnt", 32'(trk_if.err_cnt), 255);
    trk_if.en = 1'b1;
    tick(4);
    check("reen_pos",    32'(trk_if.pos),     18);

    // clr coincident with a step_up pulse
    trk_if.grey_in = to_gray(10);
    tick(3);
    check("clr_co_pulse", 32'(trk_if.step_up), 1);
    trk_if.clr = 1'b1;
    tick(1);
    trk_if.clr = 1'b0;
    check("clr_co_pos",     32'(trk_if.pos),     0);
    check("clr_co_err_cnt", 32'(trk_if.err_cnt), 0);

    // Reach pos = 7, then reset with a step inside the synchronizer
    for (int b = 11; b <= 17; b++) drive(b % 16);
    check("pre_rst_pos", 32'(trk_if.pos),     7);
    check("pre_rst_bin", 32'(trk_if.bin_out), 1);
    trk_if.grey_in = to_gray(2);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(trk_if.valid),   0);
    check("mid_rst_bin",     32'(trk_if.bin_out), 0);
    check("mid_rst_pos",     32'(trk_if.pos),     0);
    check("mid_rst_err_cnt", 32'(trk_if.err_cnt), 0);
    check("mid_rst_pulses",  32'({trk_if.step_up, trk_if.step_dn, trk_if.err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    tick(6);
    check("post_rst_pulses", 32'(n_up + n_dn + n_err), 0);
    check("post_rst_valid",  32'(trk_if.valid),   1);
    check("post_rst_bin",    32'(trk_if.bin_out), 2);
    check("post_rst_pos",    32'(trk_if.pos),     0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
